// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one physical-memory line port between the
// I-cache miss path and the D-cache miss/writeback path. One 256-bit line
// transaction is in flight at a time. The data side wins ties, but an
// anti-starvation counter hands the port to the I side after MAX_D_BURST
// consecutive D grants taken while an I request was waiting.
// Optional build macro ARB_PERF_CNT_EN adds grant and wait-cycle counters.
module cache_mem_arbiter #(
   parameter int LINE_W      = 256,
   parameter int MAX_D_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [31:0]       i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_i_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_wait_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_e;

   localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);
   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              d_pend;

   assign d_pend = d_read | d_write;

   // State, latched request and starvation counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Arbitration, request capture on grant entry, and memory/response outputs
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      i_resp      = 1'b0;
      i_rdata     = '0;
      d_resp      = 1'b0;
      d_rdata     = '0;
      case (state_q)
         IDLE: begin
            if (d_pend && !(i_read && cnt_q == MAX_CNT)) begin
               state_d = GRANT_D;
               addr_d  = d_address & LINE_MASK;
               wdata_d = d_wdata;
               wr_d    = d_write;
               if (!i_read) begin
                  cnt_d = '0;
               end else if (cnt_q != MAX_CNT) begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else if (i_read) begin
               state_d = GRANT_I;
               addr_d  = i_address & LINE_MASK;
               wdata_d = '0;
               wr_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         GRANT_I: begin
            mem_read    = 1'b1;
            mem_address = addr_q;
            if (mem_resp) begin
               i_resp  = 1'b1;
               i_rdata = mem_rdata;
               state_d = DONE;
            end
         end
         GRANT_D: begin
            mem_read    = ~wr_q;
            mem_write   = wr_q;
            mem_address = addr_q;
            mem_wdata   = wr_q ? wdata_q : '0;
            if (mem_resp) begin
               d_resp  = 1'b1;
               d_rdata = mem_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_i_q, perf_i_d;
   logic [31:0] perf_d_q, perf_d_d;
   logic [31:0] perf_wait_q, perf_wait_d;

   // Grant-entry and waiting-cycle counters; observation only
   always_comb begin
      perf_i_d    = perf_i_q;
      perf_d_d    = perf_d_q;
      perf_wait_d = perf_wait_q;
      if (state_q == IDLE && state_d == GRANT_I) begin
         perf_i_d = perf_i_q + 32'd1;
      end
      if (state_q == IDLE && state_d == GRANT_D) begin
         perf_d_d = perf_d_q + 32'd1;
      end
      if ((i_read && state_q != GRANT_I) || (d_pend && state_q != GRANT_D)) begin
         perf_wait_d = perf_wait_q + 32'd1;
      end
   end

   // Performance counter registers, wrapping naturally at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_i_q    <= '0;
         perf_d_q    <= '0;
         perf_wait_q <= '0;
      end else begin
         perf_i_q    <= perf_i_d;
         perf_d_q    <= perf_d_d;
         perf_wait_q <= perf_wait_d;
      end
   end

   assign perf_i_grants    = perf_i_q;
   assign perf_d_grants    = perf_d_q;
   assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction-level
// reference model of the arbitration rules.
module tb_cache_mem_arbiter;

   localparam int LW   = 256;
   localparam int MAXB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, d_read, d_write, mem_resp;
   logic [31:0]   i_address, d_address;
   logic [LW-1:0] d_wdata, mem_rdata;
   logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
   logic          i_resp, d_resp, mem_read, mem_write;
   logic [31:0]   mem_address;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   perf_i_grants, perf_d_grants, perf_wait_cycles;
`endif

   int checks = 0;
   int errors = 0;

   cache_mem_arbiter #(.LINE_W(LW), .MAX_D_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_wait_cycles(perf_wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        i_rd;
      logic        d_rd;
      logic        d_wr;
      logic [31:0] i_addr;
      logic [31:0] d_addr;
      logic        exp_d;
      logic        exp_wr;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, want);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_mem_read"}, LW'(mem_read), '0);
      check({tag, "_mem_write"}, LW'(mem_write), '0);
      check({tag, "_i_resp"}, LW'(i_resp), '0);
      check({tag, "_d_resp"}, LW'(d_resp), '0);
      check({tag, "_i_rdata"}, i_rdata, '0);
      check({tag, "_d_rdata"}, d_rdata, '0);
   endtask

   task automatic check_grant(input string tag, input bit exp_wr, input logic [31:0] exp_addr,
                              input logic [LW-1:0] exp_wdata);
      check({tag, "_mem_read"}, LW'(mem_read), LW'(!exp_wr));
      check({tag, "_mem_write"}, LW'(mem_write), LW'(exp_wr));
      check({tag, "_mem_address"}, LW'(mem_address), LW'(exp_addr));
      if (exp_wr) check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
   endtask

   // Caller has driven requests during an IDLE cycle; runs one transaction
   // through grant, response and turnaround, scrambling requester inputs
   // mid-grant, and returns at the start of the following IDLE cycle.
   task automatic run_txn(input string tag, input bit exp_d, input bit exp_wr,
                          input logic [31:0] exp_addr, input logic [LW-1:0] exp_wdata,
                          input int lat, input logic [LW-1:0] rdata);
      next_cycle();
      for (int k = 0; k < lat; k++) begin
         i_address = $urandom;
         d_address = 32'h0000_0200;
         d_wdata   = rand_line();
         mem_rdata = rand_line();
         #1;
         check_grant({tag, "_wait"}, exp_wr, exp_addr, exp_wdata);
         check({tag, "_wait_i_resp"}, LW'(i_resp), '0);
         check({tag, "_wait_d_resp"}, LW'(d_resp), '0);
         next_cycle();
      end
      mem_resp  = 1'b1;
      mem_rdata = rdata;
      #1;
      check_grant({tag, "_resp"}, exp_wr, exp_addr, exp_wdata);
      check({tag, "_i_resp"}, LW'(i_resp), LW'(!exp_d));
      check({tag, "_d_resp"}, LW'(d_resp), LW'(exp_d));
      check({tag, "_i_rdata"}, i_rdata, exp_d ? '0 : rdata);
      check({tag, "_d_rdata"}, d_rdata, exp_d ? rdata : '0);
      next_cycle();
      mem_resp  = 1'b0;
      mem_rdata = rand_line();
      if (exp_d) begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
      #1;
      check_quiet({tag, "_done"});
      next_cycle();
   endtask

   // Reference model state for the randomized phase
   bit            busy, cur_d, cur_wr, i_hold, d_hold, i_drop, d_drop, exp_ir, exp_dr;
   logic [31:0]   cur_addr;
   logic [LW-1:0] cur_wd, wd;
   int            lat_left, cool, dstreak, op;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h1234_567F, 32'h0,         1'b0, 1'b0, 32'h1234_5660};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'hABCD_0011, 1'b1, 1'b1, 32'hABCD_0000};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_003F, 1'b1, 1'b1, 32'h0000_0020};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, 32'h2222_2220};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1, 1'b1, 32'h4444_4440};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFE0};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'h6666_6666, 1'b1, 1'b1, 32'h6666_6660};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h7777_7777, 1'b1, 1'b0, 32'h7777_7760};

      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0;
      mem_resp = 1'b1; mem_rdata = '1;
      #2;
      check_quiet("reset");
      check("reset_mem_address", LW'(mem_address), '0);
      check("reset_mem_wdata", mem_wdata, '0);
      mem_resp = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // Lone instruction read, memory answers after 5 strobe cycles
      $display("[TB] lone I read");
      i_read = 1'b1; i_address = 32'h6000_0024;
      run_txn("lone_i", 1'b0, 1'b0, 32'h6000_0020, '0, 5, {32{8'hA5}});

      // Vector table from IDLE
      $display("[TB] vector table");
      for (int v = 0; v < 9; v++) begin
         wd = rand_line();
         i_read = vecs[v].i_rd; d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
         i_address = vecs[v].i_addr; d_address = vecs[v].d_addr; d_wdata = wd;
         run_txn($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_addr,
                 wd, v % 3 + 1, rand_line());
      end

      // Simultaneous I read and D write: D first, then the still-pending I
      $display("[TB] simultaneous requests");
      wd = rand_line();
      i_read = 1'b1; i_address = 32'h0000_1040;
      d_read = 1'b0; d_write = 1'b1; d_address = 32'h0000_2044; d_wdata = wd;
      run_txn("simul_d", 1'b1, 1'b1, 32'h0000_2040, wd, 2, rand_line());
      i_address = 32'h0000_1040;
      run_txn("simul_i", 1'b0, 1'b0, 32'h0000_1040, '0, 1, rand_line());

      // Starvation: I held while D re-requests every arbitration
      $display("[TB] starvation");
      i_read = 1'b1; i_address = 32'h0000_3000;
      for (int k = 0; k < MAXB; k++) begin
         d_read = 1'b1; d_address = 32'h0000_4000 + 32'(k) * 32'h100;
         run_txn($sformatf("starve_d%0d", k), 1'b1, 1'b0, 32'h0000_4000 + 32'(k) * 32'h100,
                 '0, 1, rand_line());
      end
      d_read = 1'b1; d_address = 32'h0000_5000; i_address = 32'h0000_3000;
      run_txn("starve_i", 1'b0, 1'b0, 32'h0000_3000, '0, 1, rand_line());
      i_read = 1'b1; i_address = 32'h0000_3100; d_address = 32'h0000_5000;
      run_txn("starve_after", 1'b1, 1'b0, 32'h0000_5000, '0, 1, rand_line());
      i_read = 1'b0;

      // Asynchronous reset in the middle of an I grant
      $display("[TB] reset mid-transaction");
      i_read = 1'b1; i_address = 32'h0000_7000;
      next_cycle();
      #1;
      check("rst_pre_mem_read", LW'(mem_read), LW'(1));
      next_cycle();
      mem_resp = 1'b1; mem_rdata = '1;
      rst = 1'b1;
      i_read = 1'b0;
      #1;
      check_quiet("rst_mid");
      check("rst_mid_mem_address", LW'(mem_address), '0);
      check("rst_mid_mem_wdata", mem_wdata, '0);
      next_cycle();
      rst = 1'b0; mem_resp = 1'b0;
      #1;
      check_quiet("rst_release");
      next_cycle();

      // Randomized traffic against the transaction-level model
      $display("[TB] random traffic");
      busy = 0; cool = 0; dstreak = 0; lat_left = 0;
      i_hold = 0; d_hold = 0; i_drop = 0; d_drop = 0;
      cur_d = 0; cur_wr = 0; cur_addr = '0; cur_wd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         next_cycle();
         if (i_drop) begin
            i_read = 1'b0; i_hold = 0; i_drop = 0;
         end else if (!i_hold && $urandom_range(3) == 0) begin
            i_hold = 1; i_read = 1'b1;
         end
         if (d_drop) begin
            d_read = 1'b0; d_write = 1'b0; d_hold = 0; d_drop = 0;
         end else if (!d_hold && $urandom_range(2) == 0) begin
            d_hold = 1; op = $urandom_range(2);
            d_read = (op != 1); d_write = (op != 0);
         end
         i_address = $urandom; d_address = $urandom; d_wdata = rand_line();
         mem_rdata = rand_line();
         if (busy && lat_left == 0) mem_resp = 1'b1;
         else mem_resp = !busy && ($urandom_range(7) == 0);
         #1;
         exp_ir = busy && !cur_d && mem_resp;
         exp_dr = busy && cur_d && mem_resp;
         check("rnd_mem_read", LW'(mem_read), LW'(busy && !cur_wr));
         check("rnd_mem_write", LW'(mem_write), LW'(busy && cur_wr));
         if (busy) check("rnd_mem_address", LW'(mem_address), LW'(cur_addr));
         if (busy && cur_wr) check("rnd_mem_wdata", mem_wdata, cur_wd);
         check("rnd_i_resp", LW'(i_resp), LW'(exp_ir));
         check("rnd_d_resp", LW'(d_resp), LW'(exp_dr));
         check("rnd_i_rdata", i_rdata, exp_ir ? mem_rdata : '0);
         check("rnd_d_rdata", d_rdata, exp_dr ? mem_rdata : '0);
         if (exp_ir) i_drop = 1;
         if (exp_dr) d_drop = 1;
         if (busy) begin
            if (mem_resp) begin
               busy = 0; cool = 1;
            end else begin
               lat_left--;
            end
         end else if (cool != 0) begin
            cool = 0;
         end else if ((d_read || d_write) && !(i_read && dstreak == MAXB)) begin
            busy = 1; cur_d = 1; cur_wr = d_write; cur_wd = d_wdata;
            cur_addr = {d_address[31:5], 5'b0};
            dstreak = i_read ? ((dstreak < MAXB) ? dstreak + 1 : MAXB) : 0;
            lat_left = $urandom_range(3);
         end else if (i_read) begin
            busy = 1; cur_d = 0; cur_wr = 0;
            cur_addr = {i_address[31:5], 5'b0};
            dstreak = 0;
            lat_left = $urandom_range(3);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core.
- Sits between the two caches' pmem interfaces and the memory/cacheline adaptor.
- Serialises one 256-bit line transaction at a time.
- Data side has priority, bounded by an anti-starvation counter for the instruction side.

Parameters:
- LINE_W, 256, line width in bits for all data buses.
- MAX_D_BURST, 4, maximum consecutive D grants while an I request is pending; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request
- i_address  in  32  I-cache line address
- i_rdata  out  LINE_W  I-cache read data
- i_resp  out  1  I-cache transaction complete
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line writeback request
- d_address  in  32  D-cache line address
- d_wdata  in  LINE_W  D-cache write data
- d_rdata  out  LINE_W  D-cache read data
- d_resp  out  1  D-cache transaction complete
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  32  memory line address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data
- mem_resp  in  1  memory transaction complete

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset: state=IDLE; starvation counter=0; all outputs 0 (mem_read, mem_write, mem_address, mem_wdata, i_resp, d_resp, i_rdata, d_rdata).
- Reset mid-transaction aborts immediately; no resp is issued; memory is assumed reset alongside.
- States: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE arbitration, per cycle:
  - Only I pending -> GRANT_I.
  - Only D pending (d_read|d_write) -> GRANT_D.
  - Both pending -> GRANT_D, unless the counter equals MAX_D_BURST, then GRANT_I.
  - Neither pending -> stay in IDLE.
- Latching on the IDLE->GRANT edge: address (low 5 bits forced to 0), wdata and op are captured into registers. Requester changes during a grant are ignored.
- d_read and d_write both high is illegal; it is treated as a write.
- GRANT_x: mem_read/mem_write driven from registered op, held constant until mem_resp.
- On the mem_resp cycle:
  - Combinational i_resp or d_resp = 1, matching the granted side, for exactly that cycle.
  - x_rdata = mem_rdata in that cycle; x_rdata = 0 otherwise.
  - Next state DONE.
- DONE: one turnaround cycle. No mem strobe, no resp, requests ignored. Requesters drop their request in this cycle. Next state IDLE.
- Latency: request first seen in IDLE at cycle n -> mem strobe at n+1 -> resp in the cycle mem_resp arrives (m) -> DONE at m+1 -> next arbitration at m+2.
- Starvation counter (4 bit):
  - Increments on each GRANT_D entry while i_read=1.
  - Clears on GRANT_I entry, or on GRANT_D entry with i_read=0.
  - Saturates at MAX_D_BURST.
- The non-granted requester sees resp=0 and rdata=0 throughout.
- mem_resp outside GRANT_x is ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds three ports:
  - perf_i_grants  out  32: count of GRANT_I entries.
  - perf_d_grants  out  32: count of GRANT_D entries.
  - perf_wait_cycles  out  32: count of cycles where a request is pending but its side is not granted.
- All three reset to 0, wrap modulo 2^32, and have no effect on arbitration.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Lone I read: i_read=1, i_address=0x60000024, memory responds after 5 cycles with 0xA5..A5 -> mem_read=1, mem_address=0x60000020, i_rdata=0xA5..A5 with i_resp=1 for one cycle; d_resp stays 0; DONE then IDLE.
- Simultaneous requests: i_read and d_write both asserted in the same IDLE cycle -> GRANT_D first with mem_write=1 and mem_wdata=d_wdata; after DONE, if only I is still pending, GRANT_I.
- Starvation, MAX_D_BURST=4: I held pending while D re-requests continuously -> exactly 4 D grants, then the 5th grant goes to I; counter reads 0 afterwards.
- Address hold: d_address is changed from 0x100 to 0x200 mid-GRANT_D -> mem_address stays 0x100 until mem_resp.
- Reset mid-transaction: rst asserted asynchronously during GRANT_I, mem_resp pending -> all outputs 0 immediately, no i_resp, state IDLE after release.
- With ARB_PERF_CNT_EN: 3 I and 2 D serialized transactions -> perf_i_grants=3, perf_d_grants=2; perf_wait_cycles equals the number of cycles a request waited.
